instruction_fetch_unit: RTL
===========================

// Module: instruction_fetch_unit
// PURPOSE
//   Initiator side of the instruction-memory interface: owns the PC, drives the
//   word address into InstructionMemory and captures the returned word.
//   Buffers fetched words in a 2-entry FIFO and presents them to decode with a
//   valid/ready handshake. Supports PC redirect (branch/jump) with flush, and
//   raises a sticky fault on misaligned or out-of-range fetch addresses.
// PARAMETERS
//   RESET_PC   32'h0000_0000  PC loaded on reset
//   MEM_WORDS  512            instruction memory depth in words; legal fetch iff PC[31:2] < MEM_WORDS
// PORTS
//   Clk             in   1   clock, rising-edge
//   Reset           in   1   asynchronous, active-low reset
//   IM_Address      out  32  byte address to InstructionMemory (= PC)
//   IM_Instruction  in   32  word returned combinationally, same cycle, for IM_Address
//   Redirect        in   1   load RedirectPC and flush buffered words
//   RedirectPC      in   32  target byte address
//   Out_Valid       out  1   head-of-FIFO entry valid
//   Out_Ready       in   1   decode accepts head this cycle
//   Out_Instruction out  32  head instruction word
//   Out_PC          out  32  byte address of head instruction
//   Out_PCPlus4     out  32  Out_PC + 4 (mod 2^32)
//   Fault           out  1   sticky: misaligned redirect or out-of-range PC
// BEHAVIOUR
//   Reset (async assert, any cycle incl. mid-redirect)
//   - PC=RESET_PC, FIFO count=0, Fault=0.
//   - Out_Valid=0; Out_Instruction/Out_PC/Out_PCPlus4=0. IM_Address=RESET_PC.
//   - The first rising edge after deassert is the first fetch edge.
//   Per-cycle terms
//   - pop  = Out_Valid & Out_Ready.
//   - legal = (PC[1:0]==0) & (PC[31:2] < MEM_WORDS).
//   - push = ~Redirect & ~Fault & legal & (count<2 | pop).
//   - On push: entry {IM_Instruction, PC} written at tail; PC <= PC+4 (wraps 32'hFFFF_FFFC -> 0).
//   - No push: PC holds; IM_Address holds.
//   - Simultaneous push and pop at count==2 allowed: count stays 2, order preserved.
//   - Latency: word fetched in cycle t is at head at t+1 if FIFO was empty.
//     Steady-state throughput 1 word/cycle with Out_Ready=1.
//   Redirect (highest priority after reset)
//   - A pop in the same cycle still counts as a completed transfer.
//   - Next edge: FIFO count=0, no push, PC <= RedirectPC.
//     Out_Valid=0 the following cycle; the target word is at head 2 cycles after Redirect.
//   - If RedirectPC[1:0]!=0: PC still loads; Fault sets next edge.
//   Fault
//   - Sets on the edge after a cycle with ~legal & ~Redirect, or after a misaligned redirect.
//   - Once set: no further pushes; buffered entries still drain via handshake.
//   - Redirect does not clear Fault; only Reset clears it.
//   Outputs
//   - Out_* reflect the FIFO head register; no combinational path from IM_Instruction to Out_*.
//   - Out_* hold stable while Out_Valid & ~Out_Ready.
//   - Combinational path Out_Ready -> push is permitted (used for the full-with-pop case).
// TESTING
//   - Reset release, Out_Ready=1, memory[i]=i*4:
//     Out_Valid rises after 1st edge; Out_Instruction=0,4,8,... on consecutive cycles;
//     Out_PC=0,4,8; Out_PCPlus4=Out_PC+4.
//   - Out_Ready=0 for 5 cycles after 3 fetches:
//     count saturates at 2, IM_Address holds at 8, head word 0 stays stable;
//     Ready=1 -> 0,4,8 delivered in order, no loss or duplicate.
//   - Redirect=1 with RedirectPC=32'h40 while FIFO full:
//     next cycle Out_Valid=0, IM_Address=32'h40;
//     following cycle head Out_PC=32'h40, Out_Instruction=32'h40.
//   - RedirectPC=32'h42: Fault=1 after edge; no further Out_Valid pulses; Reset clears Fault.
//   - PC reaches MEM_WORDS*4 (32'h800): Fault=1, last legal word 32'h7FC still delivered.
//   - Reset asserted mid-stream with Out_Valid=1:
//     Out_Valid=0 immediately (async); after release, fetch resumes at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// PC owner and fetcher into a 2-entry buffer; word fetched at cycle t is at the head at t+1.
// Backpressure: fetch stalls only when both entries are held and decode does not pop this cycle.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WORDS = 512
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic [31:0] IM_Address,
    input  logic [31:0] IM_Instruction,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic        Out_Valid,
    input  logic        Out_Ready,
    output logic [31:0] Out_Instruction,
    output logic [31:0] Out_PC,
    output logic [31:0] Out_PCPlus4,
    output logic        Fault
);

    localparam logic [30:0] MEM_LIMIT = 31'(MEM_WORDS);

    logic [31:0] pc_q, pc_d;
    logic        fault_q, fault_d;
    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [31:0] instr_q [2];
    logic [31:0] pcbuf_q [2];

    logic legal;
    logic pop;
    logic push;

    assign legal = (pc_q[1:0] == 2'b00) && ({1'b0, pc_q[31:2]} < MEM_LIMIT);
    assign pop   = Out_Valid & Out_Ready;
    // Out_Ready feeds push so a full buffer can still accept a word while draining one.
    assign push  = ~Redirect & ~fault_q & legal & ((count_q != 2'd2) | pop);

    always_comb begin
        pc_d     = pc_q;
        fault_d  = fault_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (Redirect) begin
            pc_d     = RedirectPC;
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            if (RedirectPC[1:0] != 2'b00) begin
                fault_d = 1'b1;
            end
        end else begin
            if (!legal) begin
                fault_d = 1'b1;
            end
            if (push) begin
                pc_d     = pc_q + 32'd4;
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pc_q     <= RESET_PC;
            fault_q  <= 1'b0;
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                instr_q[i] <= '0;
                pcbuf_q[i] <= '0;
            end
        end else begin
            pc_q     <= pc_d;
            fault_q  <= fault_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            if (push) begin
                instr_q[wr_ptr_q] <= IM_Instruction;
                pcbuf_q[wr_ptr_q] <= pc_q;
            end
        end
    end

    // Head fields read as zero while empty so a drained buffer looks like reset.
    assign IM_Address      = pc_q;
    assign Out_Valid       = (count_q != 2'd0);
    assign Out_Instruction = Out_Valid ? instr_q[rd_ptr_q] : 32'd0;
    assign Out_PC          = Out_Valid ? pcbuf_q[rd_ptr_q] : 32'd0;
    assign Out_PCPlus4     = Out_Valid ? (pcbuf_q[rd_ptr_q] + 32'd4) : 32'd0;
    assign Fault           = fault_q;

endmodule
